// File: rtl/uid_restore_if.sv
// rtl/uid_restore_if.sv - alloc, response, restored-beat and status signals of uid_restore
interface uid_restore_if #(
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 16
);
    localparam int IDX_W = $clog2(MAX_OUTSTANDING);
    localparam int UID_W = 2 * IDX_W;

    logic                alloc_valid;
    logic [UID_W-1:0]    alloc_uid;
    logic [ID_WIDTH-1:0] alloc_id;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [UID_W-1:0]    rsp_uid;
    logic                rsp_last;
    logic                out_valid;
    logic                out_ready;
    logic [ID_WIDTH-1:0] out_id;
    logic [UID_W-1:0]    out_uid;
    logic                out_last;
    logic                free_valid;
    logic [IDX_W-1:0]    free_row;
    logic                err_unmapped;
    logic                err_order;
    logic                err_overflow;

    modport slave (
        input  alloc_valid, alloc_uid, alloc_id,
        input  rsp_valid, rsp_uid, rsp_last,
        output rsp_ready,
        output out_valid, out_id, out_uid, out_last,
        input  out_ready,
        output free_valid, free_row,
        output err_unmapped, err_order, err_overflow
    );

    modport master (
        output alloc_valid, alloc_uid, alloc_id,
        output rsp_valid, rsp_uid, rsp_last,
        input  rsp_ready,
        input  out_valid, out_id, out_uid, out_last,
        output out_ready,
        input  free_valid, free_row,
        input  err_unmapped, err_order, err_overflow
    );
endinterface

// File: rtl/uid_restore.sv
// rtl/uid_restore.sv - restores original AXI IDs from {row, col} unique IDs on the response path
module uid_restore #(
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic         clk,
    input  logic         rst,
    uid_restore_if.slave bus
);
    localparam int IDX_W = $clog2(MAX_OUTSTANDING);
    localparam int UID_W = 2 * IDX_W;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [ID_WIDTH-1:0] row_id_q  [MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0] row_id_d  [MAX_OUTSTANDING];
    logic [CNT_W-1:0]    cnt_q     [MAX_OUTSTANDING];
    logic [CNT_W-1:0]    cnt_d     [MAX_OUTSTANDING];
    logic [IDX_W-1:0]    exp_col_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0]    exp_col_d [MAX_OUTSTANDING];

    logic                out_valid_q, out_valid_d;
    logic [ID_WIDTH-1:0] out_id_q, out_id_d;
    logic [UID_W-1:0]    out_uid_q, out_uid_d;
    logic                out_last_q, out_last_d;
    logic                free_valid_q, free_valid_d;
    logic [IDX_W-1:0]    free_row_q, free_row_d;
    logic                err_unmapped_q, err_unmapped_d;
    logic                err_order_q, err_order_d;
    logic                err_overflow_q, err_overflow_d;

    logic             rsp_ready;
    logic             acc;
    logic             unmapped;
    logic             retire;
    logic [IDX_W-1:0] a_row, a_col, r_row, r_col;

    assign a_row = bus.alloc_uid[UID_W-1:IDX_W];
    assign a_col = bus.alloc_uid[IDX_W-1:0];
    assign r_row = bus.rsp_uid[UID_W-1:IDX_W];
    assign r_col = bus.rsp_uid[IDX_W-1:0];

    always_comb begin
        row_id_d       = row_id_q;
        cnt_d          = cnt_q;
        exp_col_d      = exp_col_q;
        out_valid_d    = out_valid_q;
        out_id_d       = out_id_q;
        out_uid_d      = out_uid_q;
        out_last_d     = out_last_q;
        free_valid_d   = 1'b0;
        free_row_d     = '0;
        err_unmapped_d = 1'b0;
        err_order_d    = 1'b0;
        err_overflow_d = 1'b0;

        rsp_ready = !rst && (!out_valid_q || bus.out_ready);
        acc       = bus.rsp_valid && rsp_ready;
        unmapped  = (cnt_q[r_row] == '0);
        retire    = acc && !unmapped && bus.rsp_last;

        if (acc) begin
            out_valid_d    = 1'b1;
            out_id_d       = row_id_q[r_row];
            out_uid_d      = bus.rsp_uid;
            out_last_d     = bus.rsp_last;
            err_unmapped_d = unmapped;
            err_order_d    = !unmapped && (r_col != exp_col_q[r_row]);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (retire) begin
            cnt_d[r_row]     = cnt_q[r_row] - CNT_ONE;
            exp_col_d[r_row] = r_col + IDX_W'(1);
            if (cnt_q[r_row] == CNT_ONE) begin
                free_valid_d = 1'b1;
                free_row_d   = r_row;
            end
        end

        // A same-row alloc cancels the retire's decrement, so the row stays bound.
        if (bus.alloc_valid && !rst) begin
            if (retire && (a_row == r_row)) begin
                cnt_d[a_row] = cnt_q[a_row];
                free_valid_d = 1'b0;
                free_row_d   = '0;
            end else if (cnt_q[a_row] == '0) begin
                row_id_d[a_row]  = bus.alloc_id;
                exp_col_d[a_row] = a_col;
                cnt_d[a_row]     = CNT_ONE;
            end else if (cnt_q[a_row] == CNT_MAX) begin
                err_overflow_d = 1'b1;
            end else begin
                cnt_d[a_row] = cnt_q[a_row] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                row_id_q[i]  <= '0;
                cnt_q[i]     <= '0;
                exp_col_q[i] <= '0;
            end
            out_valid_q    <= 1'b0;
            out_id_q       <= '0;
            out_uid_q      <= '0;
            out_last_q     <= 1'b0;
            free_valid_q   <= 1'b0;
            free_row_q     <= '0;
            err_unmapped_q <= 1'b0;
            err_order_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            row_id_q       <= row_id_d;
            cnt_q          <= cnt_d;
            exp_col_q      <= exp_col_d;
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            out_uid_q      <= out_uid_d;
            out_last_q     <= out_last_d;
            free_valid_q   <= free_valid_d;
            free_row_q     <= free_row_d;
            err_unmapped_q <= err_unmapped_d;
            err_order_q    <= err_order_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign bus.rsp_ready    = rsp_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_id       = out_id_q;
    assign bus.out_uid      = out_uid_q;
    assign bus.out_last     = out_last_q;
    assign bus.free_valid   = free_valid_q;
    assign bus.free_row     = free_row_q;
    assign bus.err_unmapped = err_unmapped_q;
    assign bus.err_order    = err_order_q;
    assign bus.err_overflow = err_overflow_q;
endmodule

// File: tb/tb_uid_restore.sv
// tb/tb_uid_restore.sv - directed self-checking bench for uid_restore
module tb_uid_restore;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uid_restore_if #(.ID_WIDTH(4), .MAX_OUTSTANDING(16)) bus ();
    uid_restore #(.ID_WIDTH(4), .MAX_OUTSTANDING(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [3:0] r, input logic [3:0] c, input logic [3:0] id);
        bus.alloc_valid = 1'b1;
        bus.alloc_uid   = {r, c};
        bus.alloc_id    = id;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic set_rsp(input logic v, input logic [3:0] r, input logic [3:0] c, input logic l);
        bus.rsp_valid = v;
        bus.rsp_uid   = {r, c};
        bus.rsp_last  = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_rsp(1'b1, 4'h2, 4'h0, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready got %b exp 0", bus.rsp_ready); end
        tick();
        checks++; if (bus.rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready2 got %b exp 0", bus.rsp_ready); end
        checks++; if ({bus.out_valid, bus.out_id, bus.out_uid, bus.out_last, bus.free_valid, bus.free_row,
                       bus.err_unmapped, bus.err_order, bus.err_overflow} !== '0) begin
            errors++; $display("FAIL reset_outputs got v=%b id=%h uid=%h l=%b f=%b fr=%h e=%b%b%b exp all 0",
                bus.out_valid, bus.out_id, bus.out_uid, bus.out_last, bus.free_valid, bus.free_row,
                bus.err_unmapped, bus.err_order, bus.err_overflow); end
        rst = 1'b0;
        #1;
        checks++; if (bus.rsp_ready !== 1'b1) begin errors++; $display("FAIL release_rsp_ready got %b exp 1", bus.rsp_ready); end
        set_rsp(1'b0, 4'h0, 4'h0, 1'b0);
        tick();
    endtask

    task automatic test_basic();
        alloc(4'h3, 4'h0, 4'hA);
        set_rsp(1'b1, 4'h3, 4'h0, 1'b1);
        tick();
        set_rsp(1'b0, 4'h0, 4'h0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_id !== 4'hA) begin errors++; $display("FAIL basic_out_id got %h exp a", bus.out_id); end
        checks++; if (bus.out_uid !== 8'h30) begin errors++; $display("FAIL basic_out_uid got %h exp 30", bus.out_uid); end
        checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL basic_out_last got %b exp 1", bus.out_last); end
        checks++; if (bus.free_valid !== 1'b1 || bus.free_row !== 4'h3) begin errors++; $display("FAIL basic_free got %b/%h exp 1/3", bus.free_valid, bus.free_row); end
        checks++; if ({bus.err_unmapped, bus.err_order, bus.err_overflow} !== 3'b000) begin errors++; $display("FAIL basic_err got %b%b%b exp 000", bus.err_unmapped, bus.err_order, bus.err_overflow); end
        tick();
        checks++; if (bus.free_valid !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_end got f=%b v=%b exp 0/0", bus.free_valid, bus.out_valid); end
    endtask

    task automatic test_backpressure();
        alloc(4'h5, 4'h0, 4'h7);
        alloc(4'h5, 4'h1, 4'h7);
        alloc(4'h5, 4'h2, 4'h7);
        set_rsp(1'b1, 4'h5, 4'h0, 1'b1);
        tick();
        checks++; if (bus.out_uid !== 8'h50 || bus.out_id !== 4'h7 || bus.free_valid !== 1'b0) begin errors++; $display("FAIL bp_beat0 got uid=%h id=%h f=%b exp 50/7/0", bus.out_uid, bus.out_id, bus.free_valid); end
        set_rsp(1'b1, 4'h5, 4'h1, 1'b1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.rsp_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b exp 0", i, bus.rsp_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_uid !== 8'h50 || bus.out_id !== 4'h7 || bus.free_valid !== 1'b0) begin
                errors++; $display("FAIL bp_stall_hold[%0d] got v=%b uid=%h id=%h f=%b exp 1/50/7/0", i, bus.out_valid, bus.out_uid, bus.out_id, bus.free_valid); end
        end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_uid !== 8'h51 || bus.free_valid !== 1'b0) begin errors++; $display("FAIL bp_beat1 got uid=%h f=%b exp 51/0", bus.out_uid, bus.free_valid); end
        set_rsp(1'b1, 4'h5, 4'h2, 1'b1);
        tick();
        set_rsp(1'b0, 4'h0, 4'h0, 1'b0);
        checks++; if (bus.out_uid !== 8'h52 || bus.free_valid !== 1'b1 || bus.free_row !== 4'h5) begin errors++; $display("FAIL bp_beat2 got uid=%h f=%b fr=%h exp 52/1/5", bus.out_uid, bus.free_valid, bus.free_row); end
        checks++; if ({bus.err_unmapped, bus.err_order} !== 2'b00) begin errors++; $display("FAIL bp_err got %b%b exp 00", bus.err_unmapped, bus.err_order); end
        tick();
    endtask

    task automatic test_order();
        alloc(4'h2, 4'h4, 4'h5);
        alloc(4'h2, 4'h5, 4'h5);
        set_rsp(1'b1, 4'h2, 4'h5, 1'b1);
        tick();
        checks++; if (bus.err_order !== 1'b1) begin errors++; $display("FAIL order_err got %b exp 1", bus.err_order); end
        checks++; if (bus.out_id !== 4'h5 || bus.free_valid !== 1'b0) begin errors++; $display("FAIL order_fwd got id=%h f=%b exp 5/0", bus.out_id, bus.free_valid); end
        set_rsp(1'b1, 4'h2, 4'h6, 1'b1);
        tick();
        set_rsp(1'b0, 4'h0, 4'h0, 1'b0);
        checks++; if (bus.err_order !== 1'b0) begin errors++; $display("FAIL order_expcol6 got err=%b exp 0", bus.err_order); end
        checks++; if (bus.free_valid !== 1'b1 || bus.free_row !== 4'h2) begin errors++; $display("FAIL order_free got %b/%h exp 1/2", bus.free_valid, bus.free_row); end
        tick();
    endtask

    task automatic test_unmapped_overflow();
        set_rsp(1'b1, 4'h9, 4'h0, 1'b1);
        tick();
        set_rsp(1'b0, 4'h0, 4'h0, 1'b0);
        checks++; if (bus.err_unmapped !== 1'b1 || bus.err_order !== 1'b0) begin errors++; $display("FAIL unmapped_err got %b/%b exp 1/0", bus.err_unmapped, bus.err_order); end
        checks++; if (bus.free_valid !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_id !== 4'h0) begin errors++; $display("FAIL unmapped_fwd got f=%b v=%b id=%h exp 0/1/0", bus.free_valid, bus.out_valid, bus.out_id); end
        tick();
        for (int i = 0; i < 17; i++) begin
            alloc(4'h1, 4'(i), 4'hB);
            checks++; if (bus.err_overflow !== (i == 16)) begin errors++; $display("FAIL overflow[%0d] got %b exp %b", i, bus.err_overflow, (i == 16)); end
        end
    endtask

    task automatic test_simultaneous();
        alloc(4'h4, 4'h0, 4'h3);
        bus.alloc_valid = 1'b1;
        bus.alloc_uid   = 8'h41;
        bus.alloc_id    = 4'hC;
        set_rsp(1'b1, 4'h4, 4'h0, 1'b1);
        tick();
        bus.alloc_valid = 1'b0;
        checks++; if (bus.free_valid !== 1'b0 || bus.err_overflow !== 1'b0) begin errors++; $display("FAIL simul_nofree got f=%b ov=%b exp 0/0", bus.free_valid, bus.err_overflow); end
        checks++; if (bus.out_id !== 4'h3 || bus.err_unmapped !== 1'b0) begin errors++; $display("FAIL simul_fwd got id=%h um=%b exp 3/0", bus.out_id, bus.err_unmapped); end
        set_rsp(1'b1, 4'h4, 4'h1, 1'b1);
        tick();
        set_rsp(1'b0, 4'h0, 4'h0, 1'b0);
        checks++; if (bus.free_valid !== 1'b1 || bus.free_row !== 4'h4) begin errors++; $display("FAIL simul_free got %b/%h exp 1/4", bus.free_valid, bus.free_row); end
        checks++; if (bus.out_id !== 4'h3 || bus.err_order !== 1'b0) begin errors++; $display("FAIL simul_keep_id got id=%h ord=%b exp 3/0", bus.out_id, bus.err_order); end
        tick();
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        set_rsp(1'b1, 4'h1, 4'h0, 1'b0);
        tick();
        set_rsp(1'b0, 4'h0, 4'h0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 4'hB) begin errors++; $display("FAIL midrst_held got v=%b id=%h exp 1/b", bus.out_valid, bus.out_id); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.free_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got v=%b f=%b exp 0/0", bus.out_valid, bus.free_valid); end
        bus.out_ready = 1'b1;
        set_rsp(1'b1, 4'h1, 4'h0, 1'b1);
        tick();
        set_rsp(1'b0, 4'h0, 4'h0, 1'b0);
        checks++; if (bus.err_unmapped !== 1'b1 || bus.free_valid !== 1'b0 || bus.out_id !== 4'h0) begin errors++; $display("FAIL midrst_table got um=%b f=%b id=%h exp 1/0/0", bus.err_unmapped, bus.free_valid, bus.out_id); end
        tick();
    endtask

    initial begin
        rst             = 1'b1;
        bus.alloc_valid = 1'b0;
        bus.alloc_uid   = '0;
        bus.alloc_id    = '0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_uid     = '0;
        bus.rsp_last    = 1'b0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_order();
        test_unmapped_overflow();
        test_simultaneous();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uid_restore.md
# uid_restore

Response-path counterpart of the read-ID assigner. The assigner maps an original AXI ID to a unique ID `{row, col}`: the row identifies the original ID and the col is a per-row sequence number. This block takes the unique ID returned with each response beat and restores the original ID for the upstream master. It tracks outstanding transactions per row, checks that responses arrive in col order within each row, and frees a row once its last outstanding transaction retires.

## Interface
Parameters:
- `ID_WIDTH`, 4, width of the original AXI ID.
- `MAX_OUTSTANDING`, 16, number of rows and the col modulus; power of two, ≥2.
- `IDX_W` (localparam) = `$clog2(MAX_OUTSTANDING)`; unique ID width is `UID_W = 2*IDX_W`, laid out as `{row, col}`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `alloc_valid`  in  1  assigner granted a unique ID this cycle.
- `alloc_uid`  in  UID_W  granted `{row, col}`.
- `alloc_id`  in  ID_WIDTH  original ID bound to that grant.
- `rsp_valid`  in  1  response beat present.
- `rsp_ready`  out  1  block accepts the response beat.
- `rsp_uid`  in  UID_W  unique ID carried by the response.
- `rsp_last`  in  1  final beat of the transaction.
- `out_valid`  out  1  restored beat valid.
- `out_ready`  in  1  upstream accepts the restored beat.
- `out_id`  out  ID_WIDTH  restored original ID.
- `out_uid`  out  UID_W  echo of `rsp_uid`.
- `out_last`  out  1  echo of `rsp_last`.
- `free_valid`  out  1  one-cycle pulse: row released.
- `free_row`  out  IDX_W  row released.
- `err_unmapped`  out  1  one-cycle pulse: response for a row with count 0.
- `err_order`  out  1  one-cycle pulse: response col ≠ expected col.
- `err_overflow`  out  1  one-cycle pulse: alloc to a row already at count `MAX_OUTSTANDING`.

## Operation
- Per-row state:
  - `row_id[ID_WIDTH]`
  - `cnt[IDX_W+1]`, range 0..MAX_OUTSTANDING
  - `exp_col[IDX_W]`
- Alloc (unconditional; no backpressure):
  - If `cnt[row]==0`: `row_id <= alloc_id`, `exp_col <= col`.
  - `cnt` increments, saturating at `MAX_OUTSTANDING`. At saturation, `err_overflow` pulses and `cnt` is held.
- Response accept (`acc`) = `rsp_valid && rsp_ready`. On accept:
  - `out_id <= row_id[row]`; `out_uid`, `out_last` are captured from the response.
  - If `cnt[row]==0`:
    - `err_unmapped` pulses.
    - The beat is still forwarded with the stored `row_id`.
    - No state change.
  - Else if `col != exp_col[row]`: `err_order` pulses. The beat is still forwarded, and the last-beat bookkeeping still applies.
  - Last-beat bookkeeping (`rsp_last`):
    - `exp_col[row] <= col+1` mod `MAX_OUTSTANDING`.
    - `cnt[row]` decrements.
    - If the decrement takes `cnt` from 1 to 0, then `free_valid=1` and `free_row=row`.
- Same-row alloc and last-beat accept in the same cycle:
  - Net `cnt` is unchanged; no free and no overflow.
  - If `cnt` was 0, alloc rules apply and `err_unmapped` pulses.
  - `alloc_id` written while `cnt>0` is ignored; the row keeps its bound ID.
- Output stage: a single register slice.
  - `rsp_ready = !rst && (!out_valid || out_ready)`.
  - `out_valid` clears when `out_ready && !acc`.
  - `out_*` holds stable while `out_valid && !out_ready`.

## Timing
- Reset (cycle after `rst` is sampled high): all outputs are 0, and every `cnt`, `exp_col`, `row_id` is 0. While `rst` is high, `rsp_ready=0`, and allocs are ignored.
- Latency: beat accepted at cycle N appears on `out_*` with `out_valid=1` at N+1. `free_valid` and `err_*` assert at N+1, one cycle wide, regardless of `out_ready`.
- Throughput: one beat per cycle while `out_ready=1`.
- Alloc at cycle N is visible to a response accepted at N+1. A same-cycle alloc and response resolve per the simultaneous rule above.
- `rst` asserted mid-transaction discards the held output beat and all table state. No free pulses are emitted for discarded rows.

## Test plan
- Reset: hold `rst` 2 cycles with `rsp_valid=1` → `rsp_ready=0`, all outputs 0. First cycle after release: `rsp_ready=1`.
- Basic restore:
  - Stimulus: alloc uid {3,0} id 0xA; one cycle later, response uid {3,0}, last=1.
  - Required: next cycle `out_id=0xA`, `out_uid={3,0}`, `free_valid=1`, `free_row=3`, no errors.
- Multi-outstanding plus backpressure:
  - Stimulus: allocs {5,0},{5,1},{5,2} id 0x7; responses in order, with `out_ready=0` for 3 cycles mid-stream.
  - Required: outputs held stable during the stall, no beat lost, `free_valid` only after {5,2}.
- Order error:
  - Stimulus: allocs {2,4},{2,5}; response {2,5} first.
  - Required: `err_order=1`, `out_id` still correct, `cnt[2]` goes 2→1, `exp_col` becomes 6.
- Unmapped and overflow:
  - Stimulus A: response to an idle row 9 → `err_unmapped=1`, no free.
  - Stimulus B: 17 allocs to row 1 (`MAX_OUTSTANDING`=16) → `err_overflow=1` on the 17th.
- Simultaneous:
  - Stimulus: row 4 at `cnt=1`; alloc {4,1} in the same cycle as last-beat response {4,0}.
  - Required: no `free_valid`, `cnt[4]` stays 1, next response {4,1} frees row 4.
